// File: rtl/barrett_pkg.sv
// ============================================================================
// Module      : barrett_pkg
// Description : Shared declarations for the pipelined Barrett reducer:
//               pipeline depth, the per-stage register bundle and a helper
//               that derives the Barrett constant for a given modulus.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Contents:
//   BARRETT_LAT      pipeline latency in cycles (acceptance to out_valid)
//   BARRETT_MAX_W    largest supported MULT_WIDTH
//   BARRETT_FIELD_W  width of the data fields of stage_t
//   stage_t          {valid, p, partial} stage register bundle
//   mu_calc()        floor(2^(2k)/q), used by testbenches to derive mu
// Optional feature macro: none in this file (see BARRETT_RANGE_CHECK_EN in
// the top level).
// ============================================================================
`default_nettype none

package barrett_pkg;

    localparam int BARRETT_LAT     = 4;
    localparam int BARRETT_MAX_W   = 64;
    // Wide enough for the 2K+2-bit stage-1 product at the largest width.
    localparam int BARRETT_FIELD_W = 2 * BARRETT_MAX_W + 2;

    // Fields are sized for the widest configuration; narrower instances
    // zero-extend into them and only read the low bits they need.
    typedef struct packed {
        logic                       valid;
        logic [BARRETT_FIELD_W-1:0] p;
        logic [BARRETT_FIELD_W-1:0] partial;
    } stage_t;

    function automatic logic [BARRETT_MAX_W:0] mu_calc(
        input logic [BARRETT_MAX_W-1:0] q,
        input int unsigned              k
    );
        logic [BARRETT_FIELD_W-1:0] num;
        logic [BARRETT_FIELD_W-1:0] quo;
        num      = '0;
        num[2*k] = 1'b1;
        quo      = num / BARRETT_FIELD_W'(q);
        return quo[BARRETT_MAX_W:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cond_sub.sv
// ============================================================================
// Module      : cond_sub
// Description : Final Barrett correction. Takes r in [0, 3q) and returns
//               r mod q by subtracting 2q or q. Both comparisons are made in
//               parallel on r so the stage has a single compare depth.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   r    in   MULT_WIDTH+2  partial remainder, 0 <= r < 3q in contract
//   q    in   MULT_WIDTH    modulus
//   res  out  MULT_WIDTH    corrected residue
// Optional feature macro: none.
// ============================================================================
`default_nettype none

module cond_sub #(
    parameter int MULT_WIDTH = 64
) (
    input  logic [MULT_WIDTH+1:0] r,
    input  logic [MULT_WIDTH-1:0] q,
    output logic [MULT_WIDTH-1:0] res
);

    localparam int R_W = MULT_WIDTH + 2;

    logic [R_W-1:0] w_q1;
    logic [R_W-1:0] w_q2;
    logic [R_W-1:0] w_d1;
    logic [R_W-1:0] w_d2;
    logic [R_W-1:0] w_sel;
    logic           w_ge1;
    logic           w_ge2;

    assign w_q1  = {2'b00, q};
    assign w_q2  = {1'b0, q, 1'b0};
    assign w_ge1 = (r >= w_q1);
    assign w_ge2 = (r >= w_q2);
    assign w_d1  = r - w_q1;
    assign w_d2  = r - w_q2;

    always_comb begin
        w_sel = r;
        if (w_ge2) begin
            w_sel = w_d2;
        end else if (w_ge1) begin
            w_sel = w_d1;
        end
    end

    // Truncation also bounds out-of-contract results below 2^K.
    assign res = w_sel[MULT_WIDTH-1:0];

    logic w_unused;
    assign w_unused = ^w_sel[R_W-1:MULT_WIDTH];

endmodule

`default_nettype wire

// File: rtl/barrett_reduce_pipe.sv
// ============================================================================
// Module      : barrett_reduce_pipe
// Description : Four-stage pipelined Barrett reducer. Takes the 2K-bit
//               product p (< q^2) and returns p mod q. One result per cycle,
//               valid/ready on both sides, global stall when the output is
//               held by downstream.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1             clock, rising edge
//   rst        in   1             asynchronous active-high reset
//   q          in   K             modulus, 2^(K-1) < q < 2^K, quasi-static
//   mu         in   K+1           floor(2^(2K)/q), quasi-static
//   in_valid   in   1             prod valid
//   in_ready   out  1             prod accepted this cycle (combinational)
//   prod       in   2K            product p
//   out_valid  out  1             res valid (registered)
//   out_ready  in   1             downstream accepts res
//   res        out  K             p mod q (registered)
//   range_err  out  1             only with BARRETT_RANGE_CHECK_EN: result
//                                 came from prod >= q*q
// Optional feature macro: BARRETT_RANGE_CHECK_EN
// MULT_WIDTH must not exceed barrett_pkg::BARRETT_MAX_W.
// ============================================================================
`default_nettype none

module barrett_reduce_pipe
    import barrett_pkg::*;
#(
    parameter int MULT_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MULT_WIDTH-1:0]   q,
    input  logic [MULT_WIDTH:0]     mu,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*MULT_WIDTH-1:0] prod,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MULT_WIDTH-1:0]   res
`ifdef BARRETT_RANGE_CHECK_EN
    ,
    output logic                    range_err
`endif
);

    localparam int K    = MULT_WIDTH;
    localparam int P_W  = 2 * K;
    localparam int T1_W = 2 * K + 2;
    localparam int R_W  = K + 2;
    localparam int FW   = BARRETT_FIELD_W;

    stage_t           r_s1;
    stage_t           r_s2;
    stage_t           r_s3;
    logic             r_out_valid;
    logic [K-1:0]     r_res;

    logic             w_stall;
    logic [K:0]       w_p_hi;
    logic [T1_W-1:0]  w_t1;
    logic [K:0]       w_qhat;
    logic [R_W-1:0]   w_qhat_q;
    logic [R_W-1:0]   w_r;
    logic [K-1:0]     w_res;

    // The whole pipe freezes while the output register is held.
    assign w_stall  = r_out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    // Stage 1 operand: p >> (K-1), times mu.
    assign w_p_hi = prod[P_W-1:K-1];
    assign w_t1   = T1_W'(w_p_hi) * T1_W'(mu);

    // Stage 2: only the low K+2 bits of qhat*q matter, since r < 3q fits
    // in K+2 bits and the subtraction is done modulo 2^(K+2).
    assign w_qhat   = r_s1.partial[T1_W-1:K+1];
    assign w_qhat_q = R_W'(w_qhat) * R_W'(q);

    // Stage 3: wrap-around subtraction on the low bits.
    assign w_r = r_s2.p[R_W-1:0] - r_s2.partial[R_W-1:0];

    cond_sub #(
        .MULT_WIDTH (K)
    ) u_cond_sub (
        .r   (r_s3.partial[R_W-1:0]),
        .q   (q),
        .res (w_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_s3        <= '0;
            r_out_valid <= 1'b0;
            r_res       <= '0;
        end else if (!w_stall) begin
            // in_ready is 1 whenever we get here, so in_valid is the accept.
            r_s1.valid   <= in_valid;
            r_s1.p       <= FW'(prod);
            r_s1.partial <= FW'(w_t1);

            r_s2.valid   <= r_s1.valid;
            r_s2.p       <= r_s1.p;
            r_s2.partial <= FW'(w_qhat_q);

            // p is no longer needed once r has been formed.
            r_s3.valid   <= r_s2.valid;
            r_s3.p       <= '0;
            r_s3.partial <= FW'(w_r);

            r_out_valid  <= r_s3.valid;
            if (r_s3.valid) begin
                r_res <= w_res;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign res       = r_res;

`ifdef BARRETT_RANGE_CHECK_EN
    logic [P_W-1:0] w_q_sq;
    logic           w_range_in;
    logic           r_rng1;
    logic           r_rng2;
    logic           r_rng3;
    logic           r_range_err;

    assign w_q_sq     = P_W'(q) * P_W'(q);
    assign w_range_in = (prod >= w_q_sq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rng1      <= 1'b0;
            r_rng2      <= 1'b0;
            r_rng3      <= 1'b0;
            r_range_err <= 1'b0;
        end else if (!w_stall) begin
            r_rng1      <= w_range_in & in_valid;
            r_rng2      <= r_rng1;
            r_rng3      <= r_rng2;
            r_range_err <= r_rng3 & r_s3.valid;
        end
    end

    assign range_err = r_range_err;

    // The Barrett bounds rely on a full-width modulus.
    a_q_msb : assert property (@(posedge clk) disable iff (rst)
        in_valid |-> q[K-1]);
`endif

    // Stage bundles are sized for the widest build; collect unread bits.
    logic w_unused;
    assign w_unused = ^{r_s1, r_s2, r_s3};

endmodule

`default_nettype wire
